// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmit frame controller.
// Sequences start bit, DATA_WIDTH data bits taken from the downstream
// serializer (LSB first), an optional parity bit and a stop bit, one bit per
// baud clock. Accepts a new frame in IDLE or back-to-back during STOP.
//
// Ports:
//   clk        - TX baud clock
//   rst        - asynchronous active-low reset
//   p_data     - parallel frame data, valid while data_valid is high
//   data_valid - frame request (pulse or level)
//   par_en     - 1 = append a parity bit
//   par_typ    - 0 = even parity, 1 = odd parity
//   ser_done   - serializer done (expected only on the last data bit)
//   ser_data   - serializer registered output bit
//   ser_load   - serializer load strobe (combinational accept)
//   ser_enable - serializer shift enable (high in DATA)
//   tx_out     - UART line
//   busy       - frame in progress
//   seq_err    - sticky serializer handshake mismatch
module uart_tx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_load,
    output logic                  ser_enable,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  seq_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    state_t     state;
    state_t     state_d;
    logic [2:0] bit_cnt;
    logic       par_en_r;
    logic       parity_r;
    logic       accept;

    // Gating with rst keeps ser_load low while reset is held, so a request
    // coincident with reset never loads the serializer.
    assign accept   = data_valid & rst & ((state == IDLE) | (state == STOP));
    assign ser_load = accept;

    always_comb begin
        state_d    = state;
        tx_out     = 1'b1;
        ser_enable = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                tx_out  = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                tx_out     = ser_data;
                ser_enable = 1'b1;
                if (bit_cnt == LAST_BIT) state_d = par_en_r ? PARITY : STOP;
            end
            PARITY: begin
                tx_out  = parity_r;
                state_d = STOP;
            end
            STOP: begin
                state_d = accept ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            busy     <= 1'b0;
            seq_err  <= 1'b0;
            par_en_r <= 1'b0;
            parity_r <= 1'b0;
        end else begin
            if (accept) begin
                par_en_r <= par_en;
                parity_r <= par_typ ? ~^p_data : ^p_data;
                busy     <= 1'b1;
                seq_err  <= 1'b0;
            end else begin
                if (state == STOP) busy <= 1'b0;
                // Bit counter alone decides framing; ser_done is only audited.
                if ((state == DATA) && (ser_done != (bit_cnt == LAST_BIT)))
                    seq_err <= 1'b1;
            end

            if (state == START)     bit_cnt <= '0;
            else if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: scoreboard bench for uart_tx_fsm with a behavioural
// serializer model. Stimulus pushes expected per-cycle {tx_out, ser_enable}
// pairs for each accepted frame; a negedge monitor pops and compares them
// while busy is high and checks the idle line otherwise.
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = '0;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       ser_done;
    logic       ser_data;
    logic       ser_load;
    logic       ser_enable;
    logic       tx_out;
    logic       busy;
    logic       seq_err;

    int checks = 0;
    int errors = 0;
    int n_load = 0;
    int exp_loads = 0;
    logic done_early = 1'b0;

    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_load   (ser_load),
        .ser_enable (ser_enable),
        .tx_out     (tx_out),
        .busy       (busy),
        .seq_err    (seq_err)
    );

    // Serializer model: registered output bit, shifts on enable.
    logic [7:0] sh;
    logic       sdat;
    logic [3:0] scnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '0; sdat <= 1'b0; scnt <= '0;
        end else if (ser_load) begin
            sdat <= p_data[0]; sh <= p_data >> 1; scnt <= '0;
        end else if (ser_enable) begin
            sdat <= sh[0]; sh <= sh >> 1; scnt <= scnt + 4'd1;
        end
    end
    assign ser_data = sdat;
    assign ser_done = ser_enable && (scnt == (done_early ? 4'd6 : 4'd7));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [1:0] e;
        if (ser_load === 1'b1) n_load++;
        if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("busy_extra", {31'd0, busy}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("tx_bit", {31'd0, tx_out}, {31'd0, e[1]});
                chk("ser_enable", {31'd0, ser_enable}, {31'd0, e[0]});
            end
        end else begin
            chk("idle_line", {30'd0, tx_out, ser_enable}, 32'h2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        int ones = 0;
        exp_q.push_back(2'b00);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({d[k], 1'b1});
            if (d[k]) ones++;
        end
        if (pe) exp_q.push_back({(pt ? ((ones % 2) == 0) : ((ones % 2) == 1)), 1'b0});
        exp_q.push_back(2'b10);
    endtask

    // Issue a one-cycle request in the current cycle; returns in cycle A+1.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        push_frame(d, pe, pt);
        exp_loads++;
        #1;
        chk("load_pulse", {31'd0, ser_load}, 32'd1);
        tick();
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) chk({name, "_timeout"}, {31'd0, busy}, 32'd0);
        tick();
        chk({name, "_queue_left"}, exp_q.size(), 32'd0);
        chk({name, "_loads"}, n_load, exp_loads);
    endtask

    task automatic pulse_ignored(input string name);
        data_valid = 1'b1; p_data = 8'hFF;
        #1;
        chk(name, {31'd0, ser_load}, 32'd0);
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_tx", {31'd0, tx_out}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_en", {31'd0, ser_enable}, 32'd0);
        chk("rst_load", {31'd0, ser_load}, 32'd0);
        chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick(); tick();

        // 0x55, no parity: 10-cycle frame 0,1,0,1,0,1,0,1,0,1
        send(8'h55, 1'b0, 1'b0);
        wait_idle("f55");
        chk("f55_seq_err", {31'd0, seq_err}, 32'd0);

        // 0xA3 with even then odd parity
        send(8'hA3, 1'b1, 1'b0);
        wait_idle("fA3_even");
        send(8'hA3, 1'b1, 1'b1);
        wait_idle("fA3_odd");

        // Back-to-back: second request during first frame's STOP (A+10)
        send(8'h0F, 1'b0, 1'b0);
        repeat (9) tick();
        chk("b2b_in_stop_busy", {31'd0, busy}, 32'd1);
        send(8'hF0, 1'b0, 1'b0);
        wait_idle("b2b");

        // Requests during START, DATA and PARITY are ignored
        send(8'h96, 1'b1, 1'b0);
        pulse_ignored("ign_start");
        repeat (3) tick();
        pulse_ignored("ign_data");
        repeat (4) tick();
        pulse_ignored("ign_parity");
        wait_idle("ign");

        // Early ser_done flags seq_err without changing framing
        done_early = 1'b1;
        send(8'h3C, 1'b0, 1'b0);
        wait_idle("early");
        chk("early_seq_err", {31'd0, seq_err}, 32'd1);
        done_early = 1'b0;
        send(8'h81, 1'b0, 1'b0);
        chk("seq_err_clear", {31'd0, seq_err}, 32'd0);
        wait_idle("after_early");
        chk("after_seq_err", {31'd0, seq_err}, 32'd0);

        // Reset mid-DATA aborts immediately; request under reset is dropped
        send(8'h5A, 1'b0, 1'b0);
        repeat (4) tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_tx", {31'd0, tx_out}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_en", {31'd0, ser_enable}, 32'd0);
        p_data = 8'h77; data_valid = 1'b1;
        #1;
        chk("rst_wins_load", {31'd0, ser_load}, 32'd0);
        tick(); tick();
        data_valid = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_loads", n_load, exp_loads);

        // Recovery frame: 0x00 with odd parity -> parity bit 1
        send(8'h00, 1'b1, 1'b1);
        wait_idle("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
